puf_challenge_sequencer: RTL and testbench
==========================================

# puf_challenge_sequencer

Upstream control stage for the 3-stage arbiter PUF. It walks every challenge value and launches a timed race pulse for each one. It samples the arbiter response through a synchronizer, majority-votes it over repeated launches, and assembles the full challenge-response word. It drives the arbiter's `pulse`/`challenge` inputs and consumes its `response` output.

## Interface
Parameters:
- `CHAL_W`, 3: challenge width. The sequencer enumerates 2**CHAL_W challenges.
- `REPS`, 5: launches per challenge. Must be odd, 1..15.
- `SETUP_CYC`, 2: cycles the challenge is held stable with pulse low before launch. Must be ≥1.
- `PULSE_CYC`, 4: cycles pulse is held high before sampling. Must be ≥3, to cover the 2-flop sync.
- `RELAX_CYC`, 2: cycles pulse is held low after sampling. Must be ≥1.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a full enumeration. Sampled only in IDLE.
- `abort`, in, 1: stop the enumeration and return to IDLE.
- `pulse`, out, 1: race launch to the arbiter. Registered.
- `challenge`, out, CHAL_W: challenge to the arbiter. Registered.
- `response`, in, 1: arbiter output, asynchronous to `clk`.
- `busy`, out, 1: high in every state except IDLE.
- `bit_valid`, out, 1: one-cycle strobe when a voted bit is final.
- `bit_idx`, out, CHAL_W: challenge index of the current voted bit.
- `bit_val`, out, 1: voted response bit.
- `resp_word`, out, 2**CHAL_W: bit i holds the voted response for challenge i.
- `done`, out, 1: one-cycle strobe when the enumeration completes.

## Operation
- **States:** IDLE, SETUP, FIRE, SAMPLE, RELAX, NEXT, DONE.
- **IDLE:**
  - `start`=1 clears `resp_word`, the challenge counter, the repetition counter and the ones counter.
  - It sets `challenge`=0 and moves to SETUP.
- **SETUP:** `pulse`=0 and `challenge` is stable for SETUP_CYC cycles, then the block moves to FIRE.
- **FIRE:** `pulse`=1 for PULSE_CYC cycles, then the block moves to SAMPLE.
- **SAMPLE:** one cycle with `pulse`=1. The synchronized response is added to the ones counter (width clog2(REPS+1)). The block then moves to RELAX.
- **RELAX:** `pulse`=0 for RELAX_CYC cycles.
  - If the repetition count is below REPS−1, the count increments and the block returns to SETUP.
  - Otherwise the block moves to NEXT.
- **NEXT:** one cycle.
  - The voted bit is ones > REPS/2, using integer division.
  - The block writes `resp_word[challenge]`, drives `bit_valid`=1 with `bit_idx`=`challenge` and `bit_val`=the voted bit, then clears the ones and repetition counters.
  - If `challenge` equals 2**CHAL_W−1, the block moves to DONE. Otherwise it increments `challenge` and moves to SETUP.
- **DONE:** `done`=1 for one cycle, then IDLE. `resp_word` holds until the next accepted `start`.
- **Challenge invariant:** `challenge` changes only in cycles where `pulse`=0. The update is in NEXT, so the new value is visible in SETUP.
- **`start` while busy:** ignored.
- **`abort`:** takes priority over all transitions.
  - Next cycle: state IDLE, `pulse`=0 and `busy`=0.
  - No `done` or `bit_valid` is issued in that cycle.
  - Bits of `resp_word` already written are retained.
- **`abort` and `start` in the same cycle:** `abort` wins.
- **`challenge` counter:** never wraps during a run, because the run ends at the last index.

## Timing
- **Reset values:** `pulse`=0, `challenge`=0, `busy`=0, `bit_valid`=0, `bit_idx`=0, `bit_val`=0, `resp_word`=0, `done`=0. The synchronizer flops reset to 0 and the state resets to IDLE.
- **`rst` mid-operation:** all of the reset values apply on the next cycle. No partial strobes are emitted.
- **Response path:** 2-flop synchronizer. The value captured in SAMPLE reflects `response` from at least 2 cycles earlier, which lies inside FIRE.
- **Per launch:** SETUP_CYC + PULSE_CYC + 1 + RELAX_CYC cycles. With defaults this is 9.
- **Per challenge:** REPS × launch + 1 cycles. With defaults this is 46.
- **Done latency:** with `start` sampled in cycle 0, `done` is high in cycle 1 + 2**CHAL_W × (REPS × launch + 1). With defaults this is cycle 369.
- **First `bit_valid`:** cycle 46 with defaults. Each later strobe follows 46 cycles after the previous one.

## Structure
- **Shared package `puf_pkg`:**
  - state enum type `seq_state_t`
  - default parameter constants: `PUF_CHAL_W`=3, `PUF_REPS`=5, `PUF_SETUP_CYC`, `PUF_PULSE_CYC`, `PUF_RELAX_CYC`
- **Sub-module `resp_sync`:** generic 2-flop synchronizer with synchronous reset. It is reused by later PUF stages.
- **Top level:** FSM and counters live in `puf_challenge_sequencer`. It pairs with the arbiter at the integration level.

## Test plan
- `response` tied to 1, `start` at cycle 0 → 8 `bit_valid` strobes with `bit_idx` 0..7, `resp_word`=8'hFF, `done` exactly in cycle 369.
- Behavioural arbiter model where `response` = XOR of `challenge` bits → `resp_word`=8'h96, each `bit_val` equal to the parity of its `bit_idx`.
- Noisy model for challenge 2 returning 1,1,0,0,1 over the 5 launches, and 0,1,0,1,0 for all other challenges → bit 2 = 1, others 0, `resp_word`=8'h04.
- `abort` at cycle 100 → `pulse`=0 and `busy`=0 at cycle 101, no `done`, `resp_word[1:0]` retained; a fresh `start` then yields a full correct word.
- `rst` asserted in a FIRE cycle → every output at its reset value next cycle; a later `start` runs the full sequence normally.
- `start` pulsed while busy and `abort`+`start` in the same cycle → extra start ignored; `abort` wins. Assertion throughout: `challenge` never changes while `pulse`=1.

Source files
------------

// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and default parameters for the arbiter-PUF control path.
package puf_pkg;

  localparam int unsigned PUF_CHAL_W    = 3;
  localparam int unsigned PUF_REPS      = 5;
  localparam int unsigned PUF_SETUP_CYC = 2;
  localparam int unsigned PUF_PULSE_CYC = 4;
  localparam int unsigned PUF_RELAX_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_FIRE   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RELAX  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_t;

  // Largest of three phase lengths; sizes the shared phase timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/puf_challenge_sequencer_resp_sync.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module resp_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Enumerates every challenge, launches timed race pulses to the arbiter and
// majority-votes the synchronized response into a challenge-response word.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W    = PUF_CHAL_W,
  parameter int unsigned REPS      = PUF_REPS,
  parameter int unsigned SETUP_CYC = PUF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = PUF_PULSE_CYC,
  parameter int unsigned RELAX_CYC = PUF_RELAX_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    pulse,
  output logic [CHAL_W-1:0]       challenge,
  input  logic                    response,
  output logic                    busy,
  output logic                    bit_valid,
  output logic [CHAL_W-1:0]       bit_idx,
  output logic                    bit_val,
  output logic [(1<<CHAL_W)-1:0]  resp_word,
  output logic                    done
);

  localparam int unsigned N_CHAL  = 1 << CHAL_W;
  localparam int unsigned ONES_W  = $clog2(REPS + 1);
  localparam int unsigned REP_W   = $clog2(REPS + 1);
  localparam int unsigned TMR_W   = $clog2(max3(SETUP_CYC, PULSE_CYC, RELAX_CYC) + 1);

  localparam logic [CHAL_W-1:0] LAST_CHAL  = CHAL_W'(N_CHAL - 1);
  localparam logic [ONES_W-1:0] VOTE_THR   = ONES_W'(REPS / 2);
  localparam logic [REP_W-1:0]  LAST_REP   = REP_W'(REPS - 1);
  localparam logic [TMR_W-1:0]  SETUP_LAST = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0]  PULSE_LAST = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0]  RELAX_LAST = TMR_W'(RELAX_CYC - 1);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [TMR_W-1:0]    r_tmr;
  logic [TMR_W-1:0]    w_tmr_nxt;
  logic [REP_W-1:0]    r_rep;
  logic [REP_W-1:0]    w_rep_nxt;
  logic [ONES_W-1:0]   r_ones;
  logic [ONES_W-1:0]   w_ones_nxt;
  logic [CHAL_W-1:0]   r_chal;
  logic [CHAL_W-1:0]   w_chal_nxt;
  logic [N_CHAL-1:0]   r_resp_word;
  logic [N_CHAL-1:0]   w_word_nxt;
  logic                r_pulse;
  logic                r_busy;
  logic                r_bit_valid;
  logic                w_bit_valid_nxt;
  logic [CHAL_W-1:0]   r_bit_idx;
  logic [CHAL_W-1:0]   w_bit_idx_nxt;
  logic                r_bit_val;
  logic                w_bit_val_nxt;
  logic                r_done;
  logic                w_resp_sync;
  logic                w_vote;

  resp_sync u_resp_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (response),
    .o_q   (w_resp_sync)
  );

  assign w_vote = (r_ones > VOTE_THR);

  // Next-state and datapath updates; abort overrides everything at the end.
  always_comb begin
    w_state_nxt     = r_state;
    w_tmr_nxt       = r_tmr;
    w_rep_nxt       = r_rep;
    w_ones_nxt      = r_ones;
    w_chal_nxt      = r_chal;
    w_word_nxt      = r_resp_word;
    w_bit_valid_nxt = 1'b0;
    w_bit_idx_nxt   = r_bit_idx;
    w_bit_val_nxt   = r_bit_val;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_word_nxt  = '0;
          w_chal_nxt  = '0;
          w_rep_nxt   = '0;
          w_ones_nxt  = '0;
          w_tmr_nxt   = '0;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_tmr == SETUP_LAST) begin
          w_tmr_nxt   = '0;
          w_state_nxt = ST_FIRE;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      ST_FIRE: begin
        if (r_tmr == PULSE_LAST) begin
          w_tmr_nxt   = '0;
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      ST_SAMPLE: begin
        w_ones_nxt  = r_ones + ONES_W'(w_resp_sync);
        w_tmr_nxt   = '0;
        w_state_nxt = ST_RELAX;
      end
      ST_RELAX: begin
        if (r_tmr == RELAX_LAST) begin
          w_tmr_nxt = '0;
          if (r_rep < LAST_REP) begin
            w_rep_nxt   = r_rep + REP_W'(1);
            w_state_nxt = ST_SETUP;
          end else begin
            // Vote is final: publish it so it is visible during NEXT.
            w_word_nxt[r_chal] = w_vote;
            w_bit_valid_nxt    = 1'b1;
            w_bit_idx_nxt      = r_chal;
            w_bit_val_nxt      = w_vote;
            w_state_nxt        = ST_NEXT;
          end
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      ST_NEXT: begin
        w_ones_nxt = '0;
        w_rep_nxt  = '0;
        if (r_chal == LAST_CHAL) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_chal_nxt  = r_chal + CHAL_W'(1);
          w_state_nxt = ST_SETUP;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (abort) begin
      w_state_nxt     = ST_IDLE;
      w_tmr_nxt       = '0;
      w_chal_nxt      = r_chal;
      w_word_nxt      = r_resp_word;
      w_bit_valid_nxt = 1'b0;
      w_bit_idx_nxt   = r_bit_idx;
      w_bit_val_nxt   = r_bit_val;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_rep       <= '0;
      r_ones      <= '0;
      r_chal      <= '0;
      r_resp_word <= '0;
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_bit_valid <= 1'b0;
      r_bit_idx   <= '0;
      r_bit_val   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_rep       <= w_rep_nxt;
      r_ones      <= w_ones_nxt;
      r_chal      <= w_chal_nxt;
      r_resp_word <= w_word_nxt;
      r_pulse     <= (w_state_nxt == ST_FIRE) || (w_state_nxt == ST_SAMPLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_bit_valid <= w_bit_valid_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_bit_val   <= w_bit_val_nxt;
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign pulse     = r_pulse;
  assign challenge = r_chal;
  assign busy      = r_busy;
  assign bit_valid = r_bit_valid;
  assign bit_idx   = r_bit_idx;
  assign bit_val   = r_bit_val;
  assign resp_word = r_resp_word;
  assign done      = r_done;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench: a table-driven arbiter model feeds the sequencer and a
// monitor checks every voted bit and completion against majority votes.
module tb_puf_challenge_sequencer;

  localparam int CHAL_W    = 3;
  localparam int REPS      = 5;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 4;
  localparam int RELAX_CYC = 2;
  localparam int N_CHAL    = 1 << CHAL_W;
  localparam int LAUNCH    = SETUP_CYC + PULSE_CYC + 1 + RELAX_CYC;
  localparam int PER_CHAL  = REPS * LAUNCH + 1;
  localparam int DONE_LAT  = 1 + N_CHAL * PER_CHAL;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              pulse;
  logic [CHAL_W-1:0] challenge;
  logic              response;
  logic              busy;
  logic              bit_valid;
  logic [CHAL_W-1:0] bit_idx;
  logic              bit_val;
  logic [N_CHAL-1:0] resp_word;
  logic              done;

  puf_challenge_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pulse     (pulse),
    .challenge (challenge),
    .response  (response),
    .busy      (busy),
    .bit_valid (bit_valid),
    .bit_idx   (bit_idx),
    .bit_val   (bit_val),
    .resp_word (resp_word),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct { int idx; int val; int cyc; } exp_bit_t;
  typedef struct { int word; int cyc; } exp_done_t;
  exp_bit_t  q_bits[$];
  exp_done_t q_done[$];

  int n_checks = 0;
  int n_errors = 0;
  int t0 = 0;

  // Response of the arbiter for (challenge, launch number within challenge).
  bit tab [N_CHAL][REPS];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int vote(input int c);
    int ones;
    ones = 0;
    for (int r = 0; r < REPS; r++) ones += int'(tab[c][r]);
    return (ones > REPS / 2) ? 1 : 0;
  endfunction

  task automatic fill(input int mode);
    bit [REPS-1:0] pat_c2;
    bit [REPS-1:0] pat_other;
    bit [CHAL_W-1:0] cv;
    pat_c2    = 5'b10011;
    pat_other = 5'b01010;
    for (int c = 0; c < N_CHAL; c++) begin
      cv = CHAL_W'(c);
      for (int r = 0; r < REPS; r++) begin
        case (mode)
          0:       tab[c][r] = 1'b1;
          1:       tab[c][r] = ^cv;
          2:       tab[c][r] = (c == 2) ? pat_c2[r] : pat_other[r];
          default: tab[c][r] = 1'($urandom_range(1, 0));
        endcase
      end
    end
  endtask

  // Behavioural arbiter: launch number counts pulse falling edges per challenge.
  int              k = 0;
  logic [CHAL_W-1:0] prev_chal = '0;
  logic            prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (rst || !busy) k = 0;
    else if (prev_pulse && !pulse) k++;
    if (challenge !== prev_chal) begin
      chk("chal_change_pulse_low", int'({prev_pulse, pulse}), 0);
      k = 0;
    end
    prev_chal  = challenge;
    prev_pulse = pulse;
    response   = tab[challenge][(k < REPS) ? k : REPS - 1];
  end

  // Monitor: pops expected results whenever the DUT strobes.
  exp_bit_t  mb;
  exp_done_t md;
  always @(negedge clk) begin
    if (bit_valid) begin
      if (q_bits.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_bit_valid: got strobe idx=%0d, expected none (edge %0d)",
                 bit_idx, edge_n);
      end else begin
        mb = q_bits.pop_front();
        chk("bit_idx", int'(bit_idx), mb.idx);
        chk("bit_val", int'(bit_val), mb.val);
        chk("bit_cycle", edge_n, mb.cyc);
        chk("word_bit", int'(resp_word[bit_idx]), mb.val);
      end
    end
    if (done) begin
      if (q_done.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got strobe, expected none (edge %0d)", edge_n);
      end else begin
        md = q_done.pop_front();
        chk("done_word", int'(resp_word), md.word);
        chk("done_cycle", edge_n, md.cyc);
      end
    end
  end

  task automatic do_start(input int n_exp);
    int word;
    exp_bit_t  eb;
    exp_done_t ed;
    word = 0;
    @(negedge clk);
    start = 1'b1;
    t0 = edge_n;
    for (int i = 0; i < n_exp; i++) begin
      eb.idx = i;
      eb.val = vote(i);
      eb.cyc = t0 + PER_CHAL * (i + 1);
      q_bits.push_back(eb);
      word |= eb.val << i;
    end
    if (n_exp == N_CHAL) begin
      ed.word = word;
      ed.cyc  = t0 + DONE_LAT;
      q_done.push_back(ed);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    while (edge_n < t0 + c) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q_bits.size() != 0 || q_done.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_bits.size() != 0 || q_done.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d bits and %0d dones pending, expected 0",
               q_bits.size(), q_done.size());
      q_bits.delete();
      q_done.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic full_run();
    do_start(N_CHAL);
    wait_drain(DONE_LAT + 50);
    chk("idle_after_done", int'(busy), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pulse"},     int'(pulse), 0);
    chk({tag, "_challenge"}, int'(challenge), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_bit_valid"}, int'(bit_valid), 0);
    chk({tag, "_bit_idx"},   int'(bit_idx), 0);
    chk({tag, "_bit_val"},   int'(bit_val), 0);
    chk({tag, "_resp_word"}, int'(resp_word), 0);
    chk({tag, "_done"},      int'(done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_w;
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b1;
    fill(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    fill(0);
    full_run();
    chk("word_all_ones", int'(resp_word), 'hFF);

    fill(1);
    full_run();
    chk("word_parity", int'(resp_word), 'h96);

    fill(2);
    full_run();
    chk("word_noisy", int'(resp_word), 'h04);

    repeat (2) begin
      fill(3);
      full_run();
    end

    // Abort in cycle 100: bits 0 and 1 already written, then nothing more.
    fill(3);
    exp_w = vote(0) | (vote(1) << 1);
    do_start(2);
    wait_cycle(100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_pulse", int'(pulse), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_word_kept", int'(resp_word), exp_w);
    repeat (400) @(negedge clk);
    chk("abort_no_more_bits", q_bits.size(), 0);
    chk("abort_still_idle", int'(busy), 0);
    fill(1);
    full_run();
    chk("word_after_abort", int'(resp_word), 'h96);

    // Synchronous reset while the first race pulse is high.
    fill(0);
    do_start(0);
    n = 0;
    while (!pulse && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fire_reached", int'(pulse), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    fill(1);
    full_run();
    chk("word_after_rst", int'(resp_word), 'h96);

    // Extra start while busy is ignored; abort beats a coincident start.
    fill(3);
    do_start(1);
    wait_cycle(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycle(52);
    chk("start_ignored_chal", int'(challenge), 1);
    chk("start_ignored_busy", int'(busy), 1);
    wait_cycle(60);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_wins_busy", int'(busy), 0);
    chk("abort_wins_pulse", int'(pulse), 0);
    repeat (4) @(negedge clk);
    chk("abort_wins_stays_idle", int'(busy), 0);
    chk("abort_wins_no_bits", q_bits.size(), 0);

    fill(3);
    full_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
